// File: rtl/csr_uart_fifo_if.sv
// CSR bus bundle for csr_uart_fifo.
// The master drives the D-stage address plus the E-stage modify/wdata. The
// slave returns registered rdata/valid, which are OR-combined with the other
// CSR peripherals.
//   read   : read strobe (no side effect)
//   modify : 001 write, 010 set, 011 clear, others none
//   wdata  : write data
//   addr   : CSR address (D stage)
//   rdata  : read data, 0 when not addressed
//   valid  : addressed CSR was decoded
interface csr_uart_fifo_if;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (output read, modify, wdata, addr, input rdata, valid);
  modport slave  (input read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/csr_uart_fifo.sv
// Character UART on the CSR bus. It has parametrised TX/RX FIFOs and a
// runtime-programmable baud divider. It also keeps sticky overrun and
// framing-error flags and drives a level RX interrupt.
//   clk   : single clock domain
//   rstn  : synchronous active-low reset
//   bus   : CSR slave (addr in D stage; modify/wdata, rdata/valid in E stage)
//   rx    : asynchronous serial input
//   tx    : serial output, idle high
//   irq   : high while the RX FIFO holds data
// Data CSR read: [7:0] RX head, [8] rx_empty, [9] tx_full, [10] overrun,
// [11] frame_err. Divider CSR: [15:0], bit period = div+1 cycles, 8N1 LSB first.
module csr_uart_fifo #(
  parameter logic [11:0] BASE_ADDR  = 12'hBC0,
  parameter logic [11:0] DIV_ADDR   = 12'hBC3,
  parameter int unsigned CLOCK_RATE = 12_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned TX_LOG2    = 2,
  parameter int unsigned RX_LOG2    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  csr_uart_fifo_if.slave    bus,
  input  logic              rx,
  output logic              tx,
  output logic              irq
);

  localparam logic [15:0] DIV_RESET = 16'(CLOCK_RATE / BAUD_RATE - 1);
  localparam int unsigned TX_DEPTH  = 2 ** TX_LOG2;
  localparam int unsigned RX_DEPTH  = 2 ** RX_LOG2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- CSR decode
  logic        en_data, en_div;
  logic        data_wr, data_set, data_clr;
  logic [15:0] div;
  logic        overrun, frame_err;
  logic [31:0] data_word;

  assign data_wr  = en_data && (bus.modify == 3'b001);
  assign data_set = en_data && (bus.modify == 3'b010);
  assign data_clr = en_data && (bus.modify == 3'b011);

  logic unused_bus;
  assign unused_bus = &{1'b0, bus.read, bus.wdata[31:16]};

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_LOG2:0] tx_wp, tx_rp;
  logic             tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]       tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_LOG2] != tx_rp[TX_LOG2]) &&
                    (tx_wp[TX_LOG2-1:0] == tx_rp[TX_LOG2-1:0]);
  assign tx_push  = data_wr && !tx_full;
  assign tx_head  = tx_mem[tx_rp[TX_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TX_LOG2-1:0]] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + (TX_LOG2+1)'(1);
      if (tx_pop)  tx_rp <= tx_rp + (TX_LOG2+1)'(1);
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_LOG2:0] rx_wp, rx_rp;
  logic             rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]       rx_head, rx_sh;
  logic             rx_good, rx_bad, overrun_set;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RX_LOG2] != rx_rp[RX_LOG2]) &&
                    (rx_wp[RX_LOG2-1:0] == rx_rp[RX_LOG2-1:0]);
  assign rx_head  = rx_mem[rx_rp[RX_LOG2-1:0]];
  assign rx_pop   = data_set && !rx_empty;
  // A CPU pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_push     = rx_good && (!rx_full || rx_pop);
  assign overrun_set = rx_good && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RX_LOG2-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + (RX_LOG2+1)'(1);
      if (rx_pop)  rx_rp <= rx_rp + (RX_LOG2+1)'(1);
    end
  end

  assign irq = !rx_empty;

  // ---------------------------------------------------------------- CSR regs
  always_comb begin
    data_word = {20'b0, frame_err, overrun, tx_full, rx_empty,
                 (rx_empty ? 8'h00 : rx_head)};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      en_data   <= 1'b0;
      en_div    <= 1'b0;
      bus.valid <= 1'b0;
      bus.rdata <= '0;
    end else begin
      en_data   <= (bus.addr == BASE_ADDR);
      en_div    <= (bus.addr == DIV_ADDR);
      bus.valid <= en_data || en_div;
      if (en_data)     bus.rdata <= data_word;
      else if (en_div) bus.rdata <= {16'b0, div};
      else             bus.rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div <= DIV_RESET;
    end else if (en_div) begin
      case (bus.modify)
        3'b001:  div <= bus.wdata[15:0];
        3'b010:  div <= div | bus.wdata[15:0];
        3'b011:  div <= div & ~bus.wdata[15:0];
        default: div <= div;
      endcase
    end
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)                   overrun <= 1'b1;
      else if (data_clr && bus.wdata[10]) overrun <= 1'b0;
      if (rx_bad)                          frame_err <= 1'b1;
      else if (data_clr && bus.wdata[11]) frame_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  // The bit counter reloads from div at every bit boundary, so a new divider
  // takes effect at the next boundary.
  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_q;

  assign tx_pop = !tx_empty &&
                  ((tx_state == TX_IDLE) ||
                   ((tx_state == TX_STOP) && (tx_cnt == '0)));
  assign tx = tx_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_state <= TX_START;
            tx_sh    <= tx_head;
            tx_cnt   <= div;
            tx_q     <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= div;
            tx_bit   <= '0;
            tx_q     <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= div;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_q     <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_q   <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin // TX_STOP
          if (tx_cnt == '0) begin
            if (!tx_empty) begin
              tx_state <= TX_START;
              tx_sh    <= tx_head;
              tx_cnt   <= div;
              tx_q     <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FSM
  logic        rx_s1, rx_s2, rx_d;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [16:0] div_p1;
  logic        rx_stop_evt;

  assign div_p1      = {1'b0, div} + 17'd1;
  assign rx_stop_evt = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_good     = rx_stop_evt && rx_s2;
  assign rx_bad      = rx_stop_evt && !rx_s2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= div_p1[16:1];
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (!rx_s2) begin
              rx_state <= RX_DATA;
              rx_cnt   <= div;
              rx_bit   <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= div;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin // RX_STOP
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - 16'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Directed bench for csr_uart_fifo at 12 MHz / 1 Mbaud (div 11, 12-cycle bits).
// TX characters are queued when written and checked by a serial monitor.
// RX characters are queued when driven onto rx and checked on CSR reads.
module tb_csr_uart_fifo;
  localparam logic [11:0] BASE = 12'hBC0;
  localparam logic [11:0] DIVA = 12'hBC3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx_line = 1'b1;
  logic tx, irq;

  csr_uart_fifo_if bus();

  csr_uart_fifo #(
    .BASE_ADDR (12'hBC0),
    .DIV_ADDR  (12'hBC3),
    .CLOCK_RATE(12_000_000),
    .BAUD_RATE (1_000_000),
    .TX_LOG2   (2),
    .RX_LOG2   (2)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus),
    .rx  (rx_line),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          bit_cyc = 12;
  int          rst_cnt = 0;
  int          n_frames = 0;
  logic        mon_busy = 1'b0;
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_rx[$];
  int unsigned start_times[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic csr(input logic [11:0] a, input logic [2:0] m, input logic [31:0] w,
                     output logic [31:0] rd, output logic v);
    @(negedge clk);
    bus.addr = a; bus.modify = 3'b000; bus.wdata = '0;
    @(negedge clk);
    bus.modify = m; bus.wdata = w; bus.addr = 12'h000;
    @(negedge clk);
    bus.modify = 3'b000; bus.wdata = '0;
    rd = bus.rdata; v = bus.valid;
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] a, input logic [2:0] m,
                         input logic [31:0] w, input logic [31:0] exp);
    logic [31:0] rd;
    logic        v;
    csr(a, m, w, rd, v);
    check(tag, rd, exp);
    check({tag, "_valid"}, {31'b0, v}, 32'd1);
  endtask

  task automatic tx_write(input logic [7:0] c, input logic expect_sent);
    logic [31:0] rd;
    logic        v;
    if (expect_sent) exp_tx.push_back(c);
    csr(BASE, 3'b001, {24'b0, c}, rd, v);
  endtask

  task automatic send_rx(input logic [7:0] c, input logic stopb);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = c[i];
      repeat (bit_cyc) @(negedge clk);
    end
    rx_line = stopb;
    repeat (bit_cyc) @(negedge clk);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx_drain(input int limit, input string tag);
    int n = 0;
    while ((exp_tx.size() != 0 || mon_busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, (exp_tx.size() == 0 && !mon_busy)}, 32'd1);
  endtask

  // Serial TX monitor: samples each bit at its centre using bit_cyc.
  initial begin
    int          rc, bc;
    int unsigned t0;
    logic [7:0]  d;
    logic        s, st;
    forever begin
      @(negedge clk);
      if (rstn && tx === 1'b0) begin
        mon_busy = 1'b1;
        rc = rst_cnt; bc = bit_cyc; t0 = cyc;
        repeat (bc / 2) @(negedge clk);
        s = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (bc) @(negedge clk);
          d[i] = tx;
        end
        repeat (bc) @(negedge clk);
        st = tx;
        if (rc == rst_cnt) begin
          start_times.push_back(t0);
          check("tx_start_bit", {31'b0, s}, 32'd0);
          check("tx_stop_bit", {31'b0, st}, 32'd1);
          check("tx_frame_expected", {31'b0, exp_tx.size() != 0}, 32'd1);
          if (exp_tx.size() != 0) check("tx_char", {24'b0, d}, {24'b0, exp_tx.pop_front()});
          n_frames++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nf0, tx_low;
    int unsigned d0;
    bus.read = 1'b0; bus.modify = 3'b000; bus.wdata = '0; bus.addr = 12'h000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_valid", {31'b0, bus.valid}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rstn = 1'b1;
    csr_chk("rst_status", BASE, 3'b000, 32'd0, 32'h100);
    csr_chk("rst_div", DIVA, 3'b000, 32'd0, 32'd11);
    begin
      logic [31:0] rd;
      logic        v;
      csr(12'h123, 3'b000, 32'd0, rd, v);
      check("unaddr_rdata", rd, 32'd0);
      check("unaddr_valid", {31'b0, v}, 32'd0);
    end

    // Back-to-back characters, no idle gap
    start_times.delete();
    tx_write(8'h55, 1'b1);
    tx_write(8'hA3, 1'b1);
    wait_tx_drain(600, "b2b_drain");
    check("b2b_frames", start_times.size(), 32'd2);
    if (start_times.size() == 2) begin
      d0 = start_times[1] - start_times[0];
      check("b2b_spacing", d0, 32'd120);
    end

    // FIFO full: one char in flight, four queued, fifth dropped
    repeat (20) @(negedge clk);
    nf0 = n_frames;
    tx_write(8'h11, 1'b1);
    tx_write(8'h21, 1'b1);
    tx_write(8'h22, 1'b1);
    tx_write(8'h23, 1'b1);
    tx_write(8'h24, 1'b1);
    csr_chk("tx_full_set", BASE, 3'b000, 32'd0, 32'h300);
    tx_write(8'h25, 1'b0);
    csr_chk("tx_full_hold", BASE, 3'b000, 32'd0, 32'h300);
    wait_tx_drain(1200, "full_drain");
    check("full_frame_count", n_frames - nf0, 32'd5);
    repeat (20) @(negedge clk);

    // Single RX character, irq, pop
    exp_rx.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    check("rx_irq_set", {31'b0, irq}, 32'd1);
    csr_chk("rx_read", BASE, 3'b000, 32'd0, {24'b0, exp_rx[0]});
    csr_chk("rx_pop", BASE, 3'b010, 32'd0, {24'b0, exp_rx.pop_front()});
    csr_chk("rx_after_pop", BASE, 3'b000, 32'd0, 32'h100);
    check("rx_irq_clr", {31'b0, irq}, 32'd0);

    // Overrun: five frames into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_rx.push_back(8'(i));
      send_rx(8'(i), 1'b1);
    end
    csr_chk("ovr_set", BASE, 3'b000, 32'd0, {20'b0, 4'b0100, exp_rx[0]});
    csr_chk("ovr_clear", BASE, 3'b011, 32'h400, {20'b0, 4'b0100, exp_rx[0]});
    csr_chk("ovr_cleared", BASE, 3'b000, 32'd0, {24'b0, exp_rx[0]});
    while (exp_rx.size() != 0)
      csr_chk("ovr_drain", BASE, 3'b010, 32'd0, {24'b0, exp_rx.pop_front()});
    csr_chk("ovr_empty", BASE, 3'b000, 32'd0, 32'h100);

    // Framing error: nothing pushed
    send_rx(8'h77, 1'b0);
    check("ferr_irq", {31'b0, irq}, 32'd0);
    csr_chk("ferr_set", BASE, 3'b000, 32'd0, 32'h900);
    csr_chk("ferr_clear", BASE, 3'b011, 32'h800, 32'h900);
    csr_chk("ferr_cleared", BASE, 3'b000, 32'd0, 32'h100);

    // Divider change: 24-cycle bits
    csr_chk("div_write", DIVA, 3'b001, 32'd23, 32'd11);
    csr_chk("div_read", DIVA, 3'b000, 32'd0, 32'd23);
    bit_cyc = 24;
    start_times.delete();
    tx_write(8'h5A, 1'b1);
    tx_write(8'hC3, 1'b1);
    wait_tx_drain(1200, "div_drain");
    check("div_frames", start_times.size(), 32'd2);
    if (start_times.size() == 2) begin
      d0 = start_times[1] - start_times[0];
      check("div_spacing", d0, 32'd240);
    end
    repeat (30) @(negedge clk);

    // Reset in the middle of a frame
    nf0 = n_frames;
    tx_write(8'hF0, 1'b0);
    repeat (40) @(negedge clk);
    check("pre_rst_tx_low", {31'b0, tx}, 32'd0);
    rst_cnt++;
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", {31'b0, tx}, 32'd1);
    check("mid_rst_irq", {31'b0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bit_cyc = 12;
    csr_chk("post_rst_status", BASE, 3'b000, 32'd0, 32'h100);
    csr_chk("post_rst_div", DIVA, 3'b000, 32'd0, 32'd11);
    tx_low = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    check("post_rst_tx_idle", tx_low, 32'd0);
    check("post_rst_frames", n_frames - nf0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
